// File: rtl/qpu_exu_wbck_pkg.sv
// Shared widths and write-back source codes for the QPU EXU write-back arbiter.
// Included by the interface, the priority sub-module and the top level.
package qpu_exu_wbck_pkg;

    localparam int QPU_XLEN             = 32;
    localparam int QPU_RFIDX_REAL_WIDTH = 5;

    typedef enum logic [1:0] {
        QPU_WBCK_SRC_ALU = 2'd0,
        QPU_WBCK_SRC_QC  = 2'd1,
        QPU_WBCK_SRC_LSU = 2'd2
    } wbck_src_e;

    // One-hot grant is {lsu, qc, alu}; an empty grant maps to ALU and is
    // qualified by the caller.
    function automatic wbck_src_e grant_to_src(input logic [2:0] grant);
        wbck_src_e src;
        src = QPU_WBCK_SRC_ALU;
        if (grant[2])      src = QPU_WBCK_SRC_LSU;
        else if (grant[1]) src = QPU_WBCK_SRC_QC;
        return src;
    endfunction

endpackage

// File: rtl/qpu_exu_wbck_if.sv
// Write-back bundle between the ALU/LSU sources and the CRF write-back arbiter.
// master = source/sink side, slave = arbiter.
interface qpu_exu_wbck_if
    import qpu_exu_wbck_pkg::*;
#(
    parameter int XLEN    = QPU_XLEN,
    parameter int RFIDX_W = QPU_RFIDX_REAL_WIDTH
);
    logic               alu_wbck_valid;
    logic               alu_wbck_ready;
    logic [XLEN-1:0]    alu_wbck_data;
    logic [RFIDX_W-1:0] alu_wbck_rdidx;

    logic               qc_wbck_valid;
    logic               qc_wbck_ready;
    logic [XLEN-1:0]    qc_wbck_data;
    logic [RFIDX_W-1:0] qc_wbck_rdidx;

    logic               lsu_wbck_valid;
    logic               lsu_wbck_ready;
    logic [XLEN-1:0]    lsu_wbck_data;
    logic [RFIDX_W-1:0] lsu_wbck_rdidx;
    logic               lsu_wbck_err;

    logic               oitf_ret_ena;
    logic               crf_wbck_ena;
    logic [RFIDX_W-1:0] crf_wbck_rdidx;
    logic [XLEN-1:0]    crf_wbck_data;

    modport master (
        output alu_wbck_valid, alu_wbck_data, alu_wbck_rdidx,
        input  alu_wbck_ready,
        output qc_wbck_valid, qc_wbck_data, qc_wbck_rdidx,
        input  qc_wbck_ready,
        output lsu_wbck_valid, lsu_wbck_data, lsu_wbck_rdidx, lsu_wbck_err,
        input  lsu_wbck_ready,
        input  oitf_ret_ena, crf_wbck_ena, crf_wbck_rdidx, crf_wbck_data
    );

    modport slave (
        input  alu_wbck_valid, alu_wbck_data, alu_wbck_rdidx,
        output alu_wbck_ready,
        input  qc_wbck_valid, qc_wbck_data, qc_wbck_rdidx,
        output qc_wbck_ready,
        input  lsu_wbck_valid, lsu_wbck_data, lsu_wbck_rdidx, lsu_wbck_err,
        output lsu_wbck_ready,
        output oitf_ret_ena, crf_wbck_ena, crf_wbck_rdidx, crf_wbck_data
    );

endinterface

// File: rtl/qpu_exu_wbck_prio.sv
// Combinational 3-way priority grant: lsu > qc > alu, with the ALU promoted
// to the top when alu_promote is set. Grant is one-hot {lsu, qc, alu}.
module qpu_exu_wbck_prio
    import qpu_exu_wbck_pkg::*;
(
    input  logic       en,
    input  logic       alu_promote,
    input  logic       alu_req,
    input  logic       qc_req,
    input  logic       lsu_req,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        if (en) begin
            if (alu_promote && alu_req) grant = 3'b001;
            else if (lsu_req)           grant = 3'b100;
            else if (qc_req)            grant = 3'b010;
            else if (alu_req)           grant = 3'b001;
        end
    end

endmodule

// File: rtl/qpu_exu_wbck.sv
// CRF write-back arbiter downstream of the ALU: merges ALU, measurement and
// long-pipe results into one registered CRF write port and retires long-pipe ops.
module qpu_exu_wbck
    import qpu_exu_wbck_pkg::*;
#(
    parameter int XLEN       = QPU_XLEN,
    parameter int RFIDX_W    = QPU_RFIDX_REAL_WIDTH,
    parameter int STARVE_MAX = 4
)(
    input  logic           clk,
    input  logic           rst,
    qpu_exu_wbck_if.slave  wb
);

    logic [3:0]         starve_cnt;
    logic               alu_promote;
    logic [2:0]         grant_p0;
    wbck_src_e          src_p0;
    logic [XLEN-1:0]    sel_data_p0;
    logic [RFIDX_W-1:0] sel_rdidx_p0;
    logic               sel_ena_p0;

    assign alu_promote = (starve_cnt == 4'(STARVE_MAX));

    // Grants are suppressed during reset so sources keep their requests pending.
    qpu_exu_wbck_prio u_prio (
        .en          (~rst),
        .alu_promote (alu_promote),
        .alu_req     (wb.alu_wbck_valid),
        .qc_req      (wb.qc_wbck_valid),
        .lsu_req     (wb.lsu_wbck_valid),
        .grant       (grant_p0)
    );

    assign wb.alu_wbck_ready = grant_p0[0];
    assign wb.qc_wbck_ready  = grant_p0[1];
    assign wb.lsu_wbck_ready = grant_p0[2];
    assign wb.oitf_ret_ena   = wb.lsu_wbck_valid & grant_p0[2];

    assign src_p0 = grant_to_src(grant_p0);

    always_comb begin
        sel_data_p0  = wb.alu_wbck_data;
        sel_rdidx_p0 = wb.alu_wbck_rdidx;
        case (src_p0)
            QPU_WBCK_SRC_QC: begin
                sel_data_p0  = wb.qc_wbck_data;
                sel_rdidx_p0 = wb.qc_wbck_rdidx;
            end
            QPU_WBCK_SRC_LSU: begin
                sel_data_p0  = wb.lsu_wbck_data;
                sel_rdidx_p0 = wb.lsu_wbck_rdidx;
            end
            default: ;
        endcase
    end

    // x0 writes and errored loads are accepted but never reach the CRF.
    assign sel_ena_p0 = (|grant_p0) && (sel_rdidx_p0 != '0) &&
                        !((src_p0 == QPU_WBCK_SRC_LSU) && wb.lsu_wbck_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!wb.alu_wbck_valid || wb.alu_wbck_ready) begin
            starve_cnt <= '0;
        end else if (!alu_promote) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // ---- stage p0 -> p1: registered CRF write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wb.crf_wbck_ena   <= 1'b0;
            wb.crf_wbck_rdidx <= '0;
            wb.crf_wbck_data  <= '0;
        end else begin
            wb.crf_wbck_ena   <= sel_ena_p0;
            wb.crf_wbck_rdidx <= sel_rdidx_p0;
            wb.crf_wbck_data  <= sel_data_p0;
        end
    end

endmodule

// File: tb/tb_qpu_exu_wbck.sv
// Directed bench for the CRF write-back arbiter: reset, single source,
// three-way contention, ALU starvation, err/x0 discards and reset after a grant.
module tb_qpu_exu_wbck;
    import qpu_exu_wbck_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    qpu_exu_wbck_if #(.XLEN(32), .RFIDX_W(5)) wb ();

    qpu_exu_wbck #(.XLEN(32), .RFIDX_W(5), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_readys(input string tag, input logic a, input logic q, input logic l);
        check({tag, ".alu_ready"}, 32'(wb.alu_wbck_ready), 32'(a));
        check({tag, ".qc_ready"},  32'(wb.qc_wbck_ready),  32'(q));
        check({tag, ".lsu_ready"}, 32'(wb.lsu_wbck_ready), 32'(l));
    endtask

    task automatic check_crf(input string tag, input logic ena, input logic [4:0] idx, input logic [31:0] data);
        check({tag, ".crf_ena"}, 32'(wb.crf_wbck_ena), 32'(ena));
        if (ena) begin
            check({tag, ".crf_rdidx"}, 32'(wb.crf_wbck_rdidx), 32'(idx));
            check({tag, ".crf_data"},  wb.crf_wbck_data, data);
        end
    endtask

    initial begin
        wb.alu_wbck_valid = 1'b1; wb.alu_wbck_data = 32'h1111_0001; wb.alu_wbck_rdidx = 5'd1;
        wb.qc_wbck_valid  = 1'b1; wb.qc_wbck_data  = 32'h2222_0002; wb.qc_wbck_rdidx  = 5'd2;
        wb.lsu_wbck_valid = 1'b1; wb.lsu_wbck_data = 32'h3333_0003; wb.lsu_wbck_rdidx = 5'd3;
        wb.lsu_wbck_err   = 1'b0;

        // Reset held 3 cycles with every source requesting
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_readys("rst", 1'b0, 1'b0, 1'b0);
            check("rst.crf_ena", 32'(wb.crf_wbck_ena), 32'd0);
            check("rst.oitf", 32'(wb.oitf_ret_ena), 32'd0);
        end
        next_cycle();
        rst = 1'b0;
        wb.alu_wbck_valid = 1'b0; wb.qc_wbck_valid = 1'b0; wb.lsu_wbck_valid = 1'b0;
        #1;
        check_readys("idle", 1'b0, 1'b0, 1'b0);
        check_crf("idle", 1'b0, 5'd0, 32'd0);
        check("idle.starve", 32'(dut.starve_cnt), 32'd0);

        // ALU only
        next_cycle();
        wb.alu_wbck_valid = 1'b1; wb.alu_wbck_rdidx = 5'd5; wb.alu_wbck_data = 32'h0000_1234;
        #1;
        check_readys("alu", 1'b1, 1'b0, 1'b0);
        check("alu.oitf", 32'(wb.oitf_ret_ena), 32'd0);
        next_cycle();
        wb.alu_wbck_valid = 1'b0;
        #1;
        check_crf("alu.n1", 1'b1, 5'd5, 32'h0000_1234);
        next_cycle();
        check_crf("alu.n2", 1'b0, 5'd0, 32'd0);

        // All three valid: lsu, then qc, then alu
        next_cycle();
        wb.lsu_wbck_valid = 1'b1; wb.lsu_wbck_rdidx = 5'd3; wb.lsu_wbck_data = 32'hAAAA_0003;
        wb.qc_wbck_valid  = 1'b1; wb.qc_wbck_rdidx  = 5'd4; wb.qc_wbck_data  = 32'hBBBB_0004;
        wb.alu_wbck_valid = 1'b1; wb.alu_wbck_rdidx = 5'd7; wb.alu_wbck_data = 32'hCCCC_0007;
        #1;
        check_readys("all.n", 1'b0, 1'b0, 1'b1);
        check("all.n.oitf", 32'(wb.oitf_ret_ena), 32'd1);
        next_cycle();
        wb.lsu_wbck_valid = 1'b0;
        #1;
        check_crf("all.n1", 1'b1, 5'd3, 32'hAAAA_0003);
        check_readys("all.n1", 1'b0, 1'b1, 1'b0);
        check("all.n1.oitf", 32'(wb.oitf_ret_ena), 32'd0);
        next_cycle();
        wb.qc_wbck_valid = 1'b0;
        #1;
        check_crf("all.n2", 1'b1, 5'd4, 32'hBBBB_0004);
        check_readys("all.n2", 1'b1, 1'b0, 1'b0);
        check("all.n2.oitf", 32'(wb.oitf_ret_ena), 32'd0);
        next_cycle();
        wb.alu_wbck_valid = 1'b0;
        #1;
        check_crf("all.n3", 1'b1, 5'd7, 32'hCCCC_0007);
        next_cycle();
        check_crf("all.n4", 1'b0, 5'd0, 32'd0);

        // Continuous LSU traffic starves the ALU for STARVE_MAX cycles
        next_cycle();
        wb.lsu_wbck_valid = 1'b1; wb.lsu_wbck_rdidx = 5'd10; wb.lsu_wbck_data = 32'h0000_00A0;
        wb.alu_wbck_valid = 1'b1; wb.alu_wbck_rdidx = 5'd11; wb.alu_wbck_data = 32'h0000_00B0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("starve.cnt", 32'(dut.starve_cnt), 32'(i));
            check_readys("starve.refused", 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        check("starve.cnt_max", 32'(dut.starve_cnt), 32'd4);
        check_readys("starve.promoted", 1'b1, 1'b0, 1'b0);
        check("starve.oitf", 32'(wb.oitf_ret_ena), 32'd0);
        check_crf("starve.lsu_wr", 1'b1, 5'd10, 32'h0000_00A0);
        next_cycle();
        wb.alu_wbck_valid = 1'b0; wb.lsu_wbck_valid = 1'b0;
        #1;
        check("starve.cnt_clr", 32'(dut.starve_cnt), 32'd0);
        check_crf("starve.alu_wr", 1'b1, 5'd11, 32'h0000_00B0);
        next_cycle();
        check_crf("starve.idle", 1'b0, 5'd0, 32'd0);

        // LSU error retires without a write, then qc to x0 is discarded
        next_cycle();
        wb.lsu_wbck_valid = 1'b1; wb.lsu_wbck_err = 1'b1;
        wb.lsu_wbck_rdidx = 5'd9; wb.lsu_wbck_data = 32'hDEAD_BEEF;
        #1;
        check_readys("err", 1'b0, 1'b0, 1'b1);
        check("err.oitf", 32'(wb.oitf_ret_ena), 32'd1);
        next_cycle();
        wb.lsu_wbck_valid = 1'b0; wb.lsu_wbck_err = 1'b0;
        wb.qc_wbck_valid = 1'b1; wb.qc_wbck_rdidx = 5'd0; wb.qc_wbck_data = 32'h5555_5555;
        #1;
        check_crf("err.n1", 1'b0, 5'd0, 32'd0);
        check_readys("x0", 1'b0, 1'b1, 1'b0);
        check("x0.oitf", 32'(wb.oitf_ret_ena), 32'd0);
        next_cycle();
        wb.qc_wbck_valid = 1'b0;
        #1;
        check_crf("x0.n1", 1'b0, 5'd0, 32'd0);

        // Reset in the cycle after an ALU grant, with a second request held
        next_cycle();
        wb.alu_wbck_valid = 1'b1; wb.alu_wbck_rdidx = 5'd12; wb.alu_wbck_data = 32'h0000_0C0C;
        #1;
        check_readys("rstg", 1'b1, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b1;
        wb.alu_wbck_rdidx = 5'd13; wb.alu_wbck_data = 32'h0000_0D0D;
        #1;
        check_crf("rstg.n1", 1'b1, 5'd12, 32'h0000_0C0C);
        check_readys("rstg.in_rst", 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b0;
        #1;
        check_crf("rstg.n2", 1'b0, 5'd0, 32'd0);
        check("rstg.starve", 32'(dut.starve_cnt), 32'd0);
        check_readys("rstg.held", 1'b1, 1'b0, 1'b0);
        next_cycle();
        wb.alu_wbck_valid = 1'b0;
        #1;
        check_crf("rstg.n3", 1'b1, 5'd13, 32'h0000_0D0D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
